// File: rtl/cmlk_pkg.sv
// -----------------------------------------------------------------------------
// cmlk_pkg
// Shared definitions for the CameraLink-to-AXI4-Stream read path.
//   rd_state_e    : read-controller state encoding (S_HOLD, S_WAIT, S_RUN)
//   FRAME_LEN_DEF : default number of 32-bit words per output frame
// -----------------------------------------------------------------------------
package cmlk_pkg;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,  // FIFO reset asserted
    S_WAIT = 2'd1,  // FIFO reset released, recovery time running
    S_RUN  = 2'd2   // normal streaming
  } rd_state_e;

  localparam int unsigned FRAME_LEN_DEF = 256;

endpackage

// File: rtl/asfifo_rd_ctrl_rst_seq_cnt.sv
// -----------------------------------------------------------------------------
// rst_seq_cnt
// Down-counter that times one interval of the FIFO reset sequence.
// While en is low the counter sits at CYCLES-1; while en is high it counts
// down and done pulses in the CYCLES-th enabled cycle, after which the
// counter reloads so the same instance can time the next sequence.
// Ports:
//   clk, rst_n : read-domain clock, asynchronous active-low reset
//   en         : interval is running
//   done       : last cycle of the interval (combinational from the count)
// -----------------------------------------------------------------------------
module rst_seq_cnt #(
  parameter int unsigned CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic done
);

  localparam int unsigned   CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (!en || cnt == '0) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = en && (cnt == '0);

endmodule

// File: rtl/asfifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// asfifo_rd_ctrl
// Read-side controller of the 32-bit FWFT dual-clock FIFO. Runs the FIFO
// reset sequence (hold, then recovery wait), drains the FIFO into an
// AXI4-Stream master and cuts the stream into FRAME_LEN-word frames with
// tlast. A flush request is deferred to the next frame boundary so no
// truncated frame ever leaves the block.
// Ports:
//   clk, rst_n      : read-domain clock (FIFO rd_clk), async active-low reset
//   flush           : one-cycle request to reset the FIFO
//   fifo_rst        : registered FIFO reset
//   fifo_empty      : FIFO empty flag (FWFT)
//   fifo_dout       : FIFO head word, valid while fifo_empty is low
//   fifo_rd_en      : FIFO pop, equal to the stream handshake
//   m_axis_*        : AXI4-Stream master (tdata, tvalid, tready, tlast)
//   frame_cnt       : completed frames, wraps at 16 bits
//   busy            : reset sequence in progress
// -----------------------------------------------------------------------------
module asfifo_rd_ctrl
  import cmlk_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FRAME_LEN  = FRAME_LEN_DEF,
  parameter int unsigned RST_CYCLES = 8,
  parameter int unsigned RST_WAIT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  output logic              fifo_rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  rd_state_e   state;
  logic        flush_pend;
  logic [15:0] word_cnt;
  logic        hold_done;
  logic        wait_done;
  logic        parked;
  logic        handshake;
  logic        go_hold;

  rst_seq_cnt #(.CYCLES(RST_CYCLES)) u_hold_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == S_HOLD),
    .done (hold_done)
  );

  rst_seq_cnt #(.CYCLES(RST_WAIT)) u_wait_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == S_WAIT),
    .done (wait_done)
  );

  // Zero-latency stream path. A pending flush parks the stream at the frame
  // boundary: the next word is withheld so the reset starts right after the
  // tlast beat and the words still in the FIFO are discarded by it.
  // NOTE: every signal below is assigned on every pass through the block,
  // so no storage is implied and no latch can be inferred.
  always_comb begin
    parked        = flush_pend && (word_cnt == '0);
    m_axis_tdata  = fifo_dout;
    m_axis_tvalid = (state == S_RUN) && !fifo_empty && !parked;
    m_axis_tlast  = m_axis_tvalid && (word_cnt == LAST_IDX);
    handshake     = m_axis_tvalid && m_axis_tready;
    fifo_rd_en    = handshake;
    go_hold       = (state == S_RUN) && parked && !handshake;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HOLD;
      fifo_rst   <= 1'b1;
      busy       <= 1'b1;
      flush_pend <= 1'b0;
      word_cnt   <= '0;
      frame_cnt  <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_done) begin
            state    <= S_WAIT;
            fifo_rst <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wait_done) begin
            state <= S_RUN;
            busy  <= 1'b0;
          end
        end
        S_RUN: begin
          if (go_hold) begin
            state    <= S_HOLD;
            fifo_rst <= 1'b1;
            busy     <= 1'b1;
          end
        end
        default: begin
          state    <= S_HOLD;
          fifo_rst <= 1'b1;
          busy     <= 1'b1;
        end
      endcase

      // A request seen while a sequence is starting or running is satisfied
      // by that sequence, so clearing wins over setting.
      if (go_hold || wait_done) begin
        flush_pend <= 1'b0;
      end else if (flush) begin
        flush_pend <= 1'b1;
      end

      if (state == S_HOLD) begin
        word_cnt <= '0;
      end else if (handshake) begin
        word_cnt <= (word_cnt == LAST_IDX) ? '0 : word_cnt + 16'd1;
      end

      if (handshake && m_axis_tlast) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_asfifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_asfifo_rd_ctrl
// Bench for asfifo_rd_ctrl with FRAME_LEN=4, RST_CYCLES=8, RST_WAIT=16.
// A FWFT FIFO model feeds the DUT from a push log. A reference model driven
// by the controller rules (sequence age, pending flush, beat count) predicts
// every output each cycle; directed scenarios add latency and stream checks.
// -----------------------------------------------------------------------------
module tb_asfifo_rd_ctrl;

  localparam int FL = 4;
  localparam int RC = 8;
  localparam int RW = 16;
  localparam int DW = 32;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          flush  = 1'b0;
  logic          tready = 1'b0;
  logic          fifo_rst, fifo_empty, fifo_rd_en, tvalid, tlast, busy;
  logic [DW-1:0] fifo_dout, tdata;
  logic [15:0]   frame_cnt;

  // FIFO environment: words live in a push log, rd_ptr is the FIFO head.
  logic [DW-1:0] log_mem [0:4095];
  int unsigned   n_pushed = 0;
  int unsigned   rd_ptr   = 0;

  assign fifo_empty = (rd_ptr == n_pushed) || fifo_rst;
  assign fifo_dout  = log_mem[rd_ptr[11:0]];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rst)        rd_ptr <= n_pushed;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  asfifo_rd_ctrl #(
    .DATA_W    (DW),
    .FRAME_LEN (FL),
    .RST_CYCLES(RC),
    .RST_WAIT  (RW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fifo_rst     (fifo_rst),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rd_en   (fifo_rd_en),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast),
    .frame_cnt    (frame_cnt),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state (written only by the monitor).
  int            m_age    = 0;   // cycles into the reset sequence, -1 when streaming
  bit            m_pend   = 1'b0;
  int unsigned   m_beats  = 0;
  logic [15:0]   m_frames = '0;
  int unsigned   m_head   = 0;   // next word the stream must deliver
  logic [DW-1:0] acc_q [$];      // accepted words, as seen on the bus
  logic [DW-1:0] last_q [$];     // accepted words carrying tlast
  bit            wrap_req = 1'b0;

  always @(negedge clk) begin : monitor
    bit exp_busy, exp_valid, exp_last, hs;
    if (tvalid && tready) begin
      acc_q.push_back(tdata);
      if (tlast) last_q.push_back(tdata);
    end
    if (wrap_req) m_frames = 16'hFFFF;
    if (!rst_n) begin
      m_age = 0; m_pend = 1'b0; m_beats = 0; m_frames = '0; m_head = n_pushed;
      check("rst_fifo_rst", fifo_rst, 1);
      check("rst_busy", busy, 1);
      check("rst_tvalid", tvalid, 0);
      check("rst_tlast", tlast, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_frame_cnt", frame_cnt, 0);
    end else begin
      exp_busy  = (m_age >= 0);
      exp_valid = !exp_busy && (m_head != n_pushed) && !(m_pend && (m_beats % FL) == 0);
      exp_last  = exp_valid && ((m_beats % FL) == FL - 1);
      hs        = exp_valid && tready;
      check("busy", busy, exp_busy);
      check("fifo_rst", fifo_rst, exp_busy && m_age < RC);
      check("tvalid", tvalid, exp_valid);
      check("tlast", tlast, exp_last);
      check("rd_en", fifo_rd_en, hs);
      check("frame_cnt", frame_cnt, m_frames);
      if (exp_valid) check("tdata", tdata, log_mem[m_head[11:0]]);
      // FIFO content present during a reset cycle is lost.
      if (exp_busy && m_age < RC) m_head = n_pushed;
      if (m_age >= 0) begin
        m_age++;
        if (m_age == RC + RW) begin
          m_age  = -1;
          m_pend = 1'b0;
        end
      end else if (m_pend && (m_beats % FL) == 0 && !hs) begin
        m_age  = 0;
        m_pend = 1'b0;
      end else begin
        if (hs) begin
          m_head++;
          m_beats++;
          if ((m_beats % FL) == 0) m_frames = m_frames + 16'd1;
        end
        if (flush) m_pend = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The FIFO ignores writes while it is held in reset.
  task automatic push(input logic [DW-1:0] w);
    if (!fifo_rst && n_pushed < 4096 && (n_pushed - rd_ptr) < 200) begin
      log_mem[n_pushed[11:0]] = w;
      n_pushed++;
    end
  endtask

  // Words 0..nw-1 expected in order, tlast on every FL-th word.
  task automatic check_burst(input string tag, input int base, input int lbase,
                             input int nw, input logic [15:0] frames);
    check({tag, "_beats"}, acc_q.size() - base, nw);
    for (int i = 0; i < nw; i++) check({tag, "_word"}, acc_q[base + i], i);
    check({tag, "_lasts"}, last_q.size() - lbase, nw / FL);
    for (int i = 0; i < nw / FL; i++) check({tag, "_last"}, last_q[lbase + i], i * FL + FL - 1);
    check({tag, "_frames"}, frame_cnt, frames);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin : stim
    int n, base, lbase, rises;
    repeat (3) tick();

    // 1: release with an empty FIFO
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (fifo_rst && n < 100);
    check("s1_hold_len", n, RC);
    while (busy && n < 200) begin tick(); n++; end
    check("s1_busy_len", n, RC + RW);

    // 2: eight words, tready held high
    tready = 1'b1; base = acc_q.size(); lbase = last_q.size();
    for (int i = 0; i < 8; i++) push(i);
    repeat (12) tick();
    check_burst("s2", base, lbase, 8, 2);

    // 3: same with tready 1,0,0,1,0,0,...
    tready = 1'b0; base = acc_q.size(); lbase = last_q.size();
    for (int i = 0; i < 8; i++) push(i);
    for (int c = 0; c < 40; c++) begin tready = (c % 3 == 0); tick(); end
    check_burst("s3", base, lbase, 8, 4);

    // 4: flush after word 1 is accepted
    tready = 1'b0; base = acc_q.size(); lbase = last_q.size();
    for (int i = 0; i < 8; i++) push(i);
    tick();
    tready = 1'b1;
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    n = 0;
    while (!fifo_rst && n < 20) begin tick(); n++; end
    check("s4_flush_lat", n, 2);
    check_burst("s4", base, lbase, 4, 5);
    n = 0;
    while (fifo_rst && n < 100) begin tick(); n++; end
    check("s4_hold_len", n, RC);

    // 5: two flushes during the recovery wait
    n = 0;
    tick(); tick(); n += 2;
    flush = 1'b1; tick(); flush = 1'b0; n++;
    repeat (3) tick(); n += 3;
    flush = 1'b1; tick(); flush = 1'b0; n++;
    while (busy && n < 100) begin tick(); n++; end
    check("s5_wait_len", n, RW);
    check("s5_pend_clear", dut.flush_pend, 0);
    check("s4_residue_gone", tvalid, 0);
    check("s4_no_residue_beats", acc_q.size() - base, 4);
    base = acc_q.size(); lbase = last_q.size(); rises = 0;
    for (int i = 0; i < 4; i++) push(i);
    for (int c = 0; c < 30; c++) begin tick(); rises += fifo_rst; end
    check("s5_no_reseq", rises, 0);
    check_burst("s5", base, lbase, 4, 6);

    // 6a: frame counter wrap
    wrap_req = 1'b1;
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    wrap_req = 1'b0;
    for (int i = 0; i < 4; i++) push(i);
    repeat (8) tick();
    check("s6_wrap", frame_cnt, 16'h0000);

    // 6b: asynchronous reset in the middle of a frame
    tready = 1'b0;
    for (int i = 0; i < 4; i++) push(i);
    tick();
    tready = 1'b1;
    tick(); tick();
    tready = 1'b0;
    check("s6_pre_valid", tvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_tvalid", tvalid, 0);
    check("s6_async_fifo_rst", fifo_rst, 1);
    check("s6_async_busy", busy, 1);
    check("s6_async_frame_cnt", frame_cnt, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    check("s6_rerun_len", n, RC + RW);

    // Random traffic, backpressure and flushes against the model
    for (int c = 0; c < 1500; c++) begin
      tready = ($urandom_range(0, 9) < 7);
      flush  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 4) push($urandom);
      tick();
    end
    flush = 1'b0; tready = 1'b1;
    repeat (80) tick();
    check("rand_drained", fifo_empty, 1);
    check("rand_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
